obstacle_lane: RTL and testbench
================================

Name: obstacle_lane

Overview:
Manages up to NUM_OBS independent obstacles sharing one horizontal lane. It spawns them on a programmable frame interval, advances them once per frame while the game is playing, and retires them when they fully leave the screen. It replaces per-obstacle instancing with a pooled slot allocator feeding the renderer and collision logic. It uses incremental position updates with signed coordinates, so obstacles can be partially off-screen on either edge.

Parameters:
NUM_OBS, 4, number of obstacle slots in the lane (1..16)
X_W, 11, width of signed two's-complement x coordinate
SPD_W, 4, width of unsigned speed input (pixels per frame)
SCREEN_W, 640, visible width in pixels
OBJ_W, 16, obstacle width in pixels
CNT_W, 3, width of active_count (must hold NUM_OBS)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
gameState  in  2  00 = menu, 01 = playing, 10/11 = paused/over
frame_start  in  1  one-cycle pulse per video frame
enable  in  1  lane spawn enable; movement continues when low
direction  in  1  0 = move left, 1 = move right; sampled each frame step
speed  in  SPD_W  pixels added/subtracted per frame step
spawn_interval  in  8  frames between spawns; 0 treated as 1
lane_y  in  9  lane y coordinate
obs_x  out  NUM_OBS*X_W  packed signed x per slot, slot i at [i*X_W +: X_W]
obs_y  out  9  registered lane_y, updated on every frame step
obs_valid  out  NUM_OBS  slot i holds a live obstacle
active_count  out  CNT_W  popcount of obs_valid
spawn_drop  out  1  one-cycle pulse: spawn due but no free slot

Behaviour:
- Reset: obs_x all 0, obs_valid 0, active_count 0, obs_y 0, spawn_drop 0, frame counter 0. Reset has priority over every other input, including mid-frame-step.
- Frame step = frame_start && gameState==01. All updates occur in that single cycle. Outputs are registered and visible the cycle after the step.
- gameState==00 on any cycle: clear all obs_valid and the frame counter. obs_x is left unchanged.
- gameState 10/11: full freeze. No movement, no counting, no spawning.
- Per slot, on a frame step:
  - If valid, x_new = x - speed (dir 0) or x + speed (dir 1).
  - speed is zero-extended to X_W.
  - Arithmetic is signed X_W; no modulo and no wrap.
  - Retire (valid<=0, obs_x holds x_new) if dir 0 and x_new <= -OBJ_W, or if dir 1 and x_new >= SCREEN_W.
  - A retired slot is not reusable until the next frame step.
- Spawn counter:
  - On each frame step with enable=1: if counter+1 >= eff_interval then spawn_due and counter<=0, else counter<=counter+1.
  - eff_interval = max(spawn_interval, 1).
  - With enable=0, the counter holds and no spawn occurs.
- Spawn:
  - When spawn_due, allocate the lowest-index slot that was invalid before this step.
  - Set x = SCREEN_W if dir 0, or x = -OBJ_W if dir 1, and set valid=1.
  - A spawned obstacle does not move during its spawn step.
- No free slot at spawn_due: spawn_drop=1 for exactly that cycle. The counter still reloads to 0.
- A direction change mid-flight applies to all live obstacles from that step on. Retire checks use the current direction.
- active_count is registered and consistent with obs_valid in the same cycle.
- frame_start while reset=1 is ignored.

Test Plan:
- Reset, then gameState=01, enable=1, dir=0, speed=4, interval=3, 3 frame steps -> after step 3 obs_valid=0001, obs_x[0]=640; after step 4 obs_x[0]=636.
- Single obstacle dir=0, speed=8, started at x=-1 -> next step x_new=-9, still valid; step after that x=-17 <= -16, obs_valid[0]=0, active_count decrements.
- NUM_OBS=4, interval=1, speed=1, 5 steps -> slots 0..3 spawned on steps 1..4, obs_valid=1111, active_count=4; step 5 gives spawn_drop high for 1 cycle and no state change.
- dir=1, speed=15, spawn -> x=-16 then -1, 14, ... ; retires on the step where x >= 640.
- Mid-run gameState=10 for 10 frame_start pulses -> obs_x, counter, and obs_valid unchanged; then gameState=00 for one cycle -> obs_valid=0, counter=0.
- Assert reset in the same cycle as a frame step with spawn_due -> all outputs at reset values next cycle, no spawn; interval=0 then behaves as interval=1 (spawn every step).

Source files
------------

// File: rtl/obstacle_lane.sv
// Pooled obstacle lane: spawns obstacles on a frame interval, moves them once per playing
// frame and retires them once they have fully left the screen.
module obstacle_lane #(
    parameter int NUM_OBS  = 4,
    parameter int X_W      = 11,
    parameter int SPD_W    = 4,
    parameter int SCREEN_W = 640,
    parameter int OBJ_W    = 16,
    parameter int CNT_W    = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [1:0]             gameState,
    input  logic                   frame_start,
    input  logic                   enable,
    input  logic                   direction,
    input  logic [SPD_W-1:0]       speed,
    input  logic [7:0]             spawn_interval,
    input  logic [8:0]             lane_y,
    output logic [NUM_OBS*X_W-1:0] obs_x,
    output logic [8:0]             obs_y,
    output logic [NUM_OBS-1:0]     obs_valid,
    output logic [CNT_W-1:0]       active_count,
    output logic                   spawn_drop
);

    localparam logic signed [X_W-1:0] RIGHT_EDGE = X_W'(SCREEN_W);
    localparam logic signed [X_W-1:0] LEFT_EDGE  = X_W'(-OBJ_W);

    logic [NUM_OBS-1:0][X_W-1:0] x_q, x_d;
    logic [NUM_OBS-1:0]          valid_q, valid_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [8:0]                  y_q, y_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        drop_q, drop_d;

    logic                        frame_step;
    logic                        spawn_due;
    logic                        found;
    logic [7:0]                  eff_interval;
    logic signed [X_W-1:0]       spd_ext;
    logic signed [X_W-1:0]       x_cur;
    logic signed [X_W-1:0]       x_new;

    assign frame_step   = frame_start && (gameState == 2'b01);
    assign eff_interval = (spawn_interval == 8'd0) ? 8'd1 : spawn_interval;
    assign spd_ext      = $signed({{(X_W-SPD_W){1'b0}}, speed});

    always_comb begin
        x_d       = x_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        drop_d    = 1'b0;
        spawn_due = 1'b0;
        found     = 1'b0;
        x_cur     = '0;
        x_new     = '0;
        count_d   = '0;

        if (gameState == 2'b00) begin
            valid_d = '0;
            cnt_d   = '0;
        end else if (frame_step) begin
            y_d = lane_y;
            for (int i = 0; i < NUM_OBS; i++) begin
                if (valid_q[i]) begin
                    x_cur = $signed(x_q[i]);
                    x_new = direction ? (x_cur + spd_ext) : (x_cur - spd_ext);
                    x_d[i] = x_new;
                    if (direction ? (x_new >= RIGHT_EDGE) : (x_new <= LEFT_EDGE)) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end

            if (enable) begin
                if (({1'b0, cnt_q} + 9'd1) >= {1'b0, eff_interval}) begin
                    spawn_due = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // Allocation looks at pre-step validity so a slot retired this step stays unused.
            if (spawn_due) begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (!found && !valid_q[i]) begin
                        found      = 1'b1;
                        valid_d[i] = 1'b1;
                        x_d[i]     = direction ? LEFT_EDGE : RIGHT_EDGE;
                    end
                end
                drop_d = !found;
            end
        end

        for (int i = 0; i < NUM_OBS; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_q     <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign obs_x        = x_q;
    assign obs_y        = y_q;
    assign obs_valid    = valid_q;
    assign active_count = count_q;
    assign spawn_drop   = drop_q;

endmodule

// File: tb/tb_obstacle_lane.sv
// Directed bench for obstacle_lane: spawn timing, edge retirement, pool exhaustion,
// pause/menu behaviour and reset priority.
module tb_obstacle_lane;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [1:0]  gameState;
    logic        frame_start;
    logic        enable;
    logic        direction;
    logic [3:0]  speed;
    logic [7:0]  spawn_interval;
    logic [8:0]  lane_y;
    logic [43:0] obs_x;
    logic [8:0]  obs_y;
    logic [3:0]  obs_valid;
    logic [2:0]  active_count;
    logic        spawn_drop;

    int checks = 0;
    int errors = 0;

    obstacle_lane dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .gameState     (gameState),
        .frame_start   (frame_start),
        .enable        (enable),
        .direction     (direction),
        .speed         (speed),
        .spawn_interval(spawn_interval),
        .lane_y        (lane_y),
        .obs_x         (obs_x),
        .obs_y         (obs_y),
        .obs_valid     (obs_valid),
        .active_count  (active_count),
        .spawn_drop    (spawn_drop)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [10:0] sx(input int v);
        return 11'(v);
    endfunction

    function automatic logic [10:0] slot_x(input int i);
        return obs_x[i*11 +: 11];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame_start pulse; returns at the negedge after the sampling posedge.
    task automatic step();
        @(negedge CLOCK_50);
        frame_start = 1'b1;
        @(negedge CLOCK_50);
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        gameState      = 2'b00;
        frame_start    = 1'b0;
        enable         = 1'b0;
        direction      = 1'b0;
        speed          = 4'd0;
        spawn_interval = 8'd0;
        lane_y         = 9'd100;

        // Reset values
        do_reset();
        check("rst_valid", 64'(obs_valid), 64'h0);
        check("rst_count", 64'(active_count), 64'h0);
        check("rst_x", 64'(obs_x), 64'h0);
        check("rst_y", 64'(obs_y), 64'h0);
        check("rst_drop", 64'(spawn_drop), 64'h0);

        // Interval 3: first spawn on step 3 at the right edge
        gameState      = 2'b01;
        enable         = 1'b1;
        speed          = 4'd4;
        spawn_interval = 8'd3;
        step();
        step();
        check("int3_step2_valid", 64'(obs_valid), 64'h0);
        step();
        check("int3_step3_valid", 64'(obs_valid), 64'h1);
        check("int3_step3_x0", 64'(slot_x(0)), 64'(sx(640)));
        check("int3_step3_y", 64'(obs_y), 64'd100);
        check("int3_step3_count", 64'(active_count), 64'h1);
        step();
        check("int3_step4_x0", 64'(slot_x(0)), 64'(sx(636)));

        // Left-edge retirement hits exactly -OBJ_W
        enable = 1'b0;
        for (int i = 0; i < 159; i++) step();
        check("left_x0_zero", 64'(slot_x(0)), 64'(sx(0)));
        speed = 4'd8;
        step();
        check("left_x0_m8", 64'(slot_x(0)), 64'(sx(-8)));
        check("left_m8_valid", 64'(obs_valid), 64'h1);
        step();
        check("left_retire_valid", 64'(obs_valid), 64'h0);
        check("left_retire_count", 64'(active_count), 64'h0);
        check("left_retire_x0", 64'(slot_x(0)), 64'(sx(-16)));

        // Pool exhaustion with interval 1
        do_reset();
        gameState      = 2'b01;
        enable         = 1'b1;
        direction      = 1'b0;
        speed          = 4'd1;
        spawn_interval = 8'd1;
        for (int i = 0; i < 4; i++) step();
        check("fill_valid", 64'(obs_valid), 64'hF);
        check("fill_count", 64'(active_count), 64'd4);
        check("fill_x0", 64'(slot_x(0)), 64'(sx(637)));
        check("fill_x3", 64'(slot_x(3)), 64'(sx(640)));
        step();
        check("drop_pulse", 64'(spawn_drop), 64'h1);
        check("drop_valid", 64'(obs_valid), 64'hF);
        check("drop_x0", 64'(slot_x(0)), 64'(sx(636)));
        @(negedge CLOCK_50);
        check("drop_one_cycle", 64'(spawn_drop), 64'h0);

        // Pause freezes movement and the spawn counter
        spawn_interval = 8'd3;
        step();
        check("pre_pause_drop", 64'(spawn_drop), 64'h0);
        gameState = 2'b10;
        for (int i = 0; i < 10; i++) step();
        check("pause_x0", 64'(slot_x(0)), 64'(sx(635)));
        check("pause_valid", 64'(obs_valid), 64'hF);
        check("pause_count", 64'(active_count), 64'd4);
        gameState = 2'b01;
        step();
        check("resume1_drop", 64'(spawn_drop), 64'h0);
        check("resume1_x0", 64'(slot_x(0)), 64'(sx(634)));
        step();
        check("resume2_drop", 64'(spawn_drop), 64'h1);
        step();
        check("resume3_x0", 64'(slot_x(0)), 64'(sx(632)));

        // Menu clears validity and counter but keeps x
        @(negedge CLOCK_50);
        gameState = 2'b00;
        @(negedge CLOCK_50);
        gameState = 2'b01;
        check("menu_valid", 64'(obs_valid), 64'h0);
        check("menu_count", 64'(active_count), 64'h0);
        check("menu_x0", 64'(slot_x(0)), 64'(sx(632)));
        step();
        step();
        check("menu_cnt_cleared", 64'(obs_valid), 64'h0);
        step();
        check("menu_spawn_valid", 64'(obs_valid), 64'h1);
        check("menu_spawn_x0", 64'(slot_x(0)), 64'(sx(640)));

        // Rightward motion and right-edge retirement at exactly SCREEN_W
        do_reset();
        gameState      = 2'b01;
        direction      = 1'b1;
        speed          = 4'd15;
        spawn_interval = 8'd1;
        enable         = 1'b1;
        step();
        check("right_spawn_x0", 64'(slot_x(0)), 64'(sx(-16)));
        enable = 1'b0;
        step();
        check("right_x0_m1", 64'(slot_x(0)), 64'(sx(-1)));
        step();
        check("right_x0_14", 64'(slot_x(0)), 64'(sx(14)));
        for (int i = 0; i < 41; i++) step();
        check("right_x0_629", 64'(slot_x(0)), 64'(sx(629)));
        check("right_629_valid", 64'(obs_valid), 64'h1);
        speed = 4'd11;
        step();
        check("right_retire_x0", 64'(slot_x(0)), 64'(sx(640)));
        check("right_retire_valid", 64'(obs_valid), 64'h0);

        // Reset wins over a frame step with a spawn due
        speed  = 4'd15;
        enable = 1'b1;
        @(negedge CLOCK_50);
        reset       = 1'b1;
        frame_start = 1'b1;
        @(negedge CLOCK_50);
        reset       = 1'b0;
        frame_start = 1'b0;
        check("rst_step_valid", 64'(obs_valid), 64'h0);
        check("rst_step_x", 64'(obs_x), 64'h0);
        check("rst_step_count", 64'(active_count), 64'h0);
        check("rst_step_drop", 64'(spawn_drop), 64'h0);
        check("rst_step_y", 64'(obs_y), 64'h0);

        // Interval 0 behaves as 1
        spawn_interval = 8'd0;
        lane_y         = 9'd200;
        step();
        check("int0_step1_valid", 64'(obs_valid), 64'h1);
        check("int0_step1_y", 64'(obs_y), 64'd200);
        step();
        check("int0_step2_valid", 64'(obs_valid), 64'h3);
        check("int0_step2_x0", 64'(slot_x(0)), 64'(sx(-1)));
        check("int0_step2_x1", 64'(slot_x(1)), 64'(sx(-16)));
        check("int0_step2_count", 64'(active_count), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
